// File: rtl/microsequencer.sv
// microsequencer: next-address logic and micro-PC register for the
// microprogrammed control unit. It turns the per-cycle next-state action
// into the control-store address for the next cycle. It also provides
// memory-wait stalls with a handshake watchdog, a one-deep subroutine
// return register, and sticky fault reporting.
module microsequencer #(
  parameter int            AW        = 8,
  parameter logic [AW-1:0] TRAP_ADDR = 8'hFF,
  parameter int            TIMEOUT   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    ns_sel,
  input  logic          cond,
  input  logic [AW-1:0] ir_entry,
  input  logic          ir_valid,
  input  logic [AW-1:0] cr_target,
  input  logic          moc,
  output logic [AW-1:0] state,
  output logic [AW-1:0] next_state,
  output logic          stall,
  output logic [1:0]    fault,
  output logic          fault_pulse
);

  typedef enum logic [2:0] {
    NS_FETCH  = 3'd0,
    NS_INC    = 3'd1,
    NS_DECODE = 3'd2,
    NS_BRT    = 3'd3,
    NS_BRF    = 3'd4,
    NS_CALL   = 3'd5,
    NS_RET    = 3'd6,
    NS_WAIT   = 3'd7
  } ns_action_e;

  typedef enum logic [1:0] {
    FLT_NONE      = 2'd0,
    FLT_ILLEGAL   = 2'd1,
    FLT_UNDERFLOW = 2'd2,
    FLT_TIMEOUT   = 2'd3
  } fault_e;

  // The watchdog counter only has to reach TIMEOUT-1.
  localparam int            WCW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(TIMEOUT - 1);

  logic [AW-1:0]  incr;
  logic [AW-1:0]  ret_reg, ret_reg_nxt;
  logic           ret_valid, ret_valid_nxt;
  logic [WCW-1:0] wcnt, wcnt_nxt;
  logic           fault_take;
  fault_e         fault_code;

  // Stall is informational: the datapath holds its register enables on it.
  assign stall = (ns_sel == NS_WAIT) && !moc;

  // Next-address selection, subroutine bookkeeping, watchdog and fault detection.
  always_comb begin
    // NOTE: every output of this block gets a default first, so that no
    // path through the case leaves a signal unassigned and infers a latch.
    incr          = state + AW'(1);
    next_state    = incr;
    ret_reg_nxt   = ret_reg;
    ret_valid_nxt = ret_valid;
    wcnt_nxt      = '0;
    fault_take    = 1'b0;
    fault_code    = FLT_NONE;

    case (ns_sel)
      NS_FETCH:  next_state = '0;
      NS_INC:    next_state = incr;
      NS_DECODE: begin
        if (ir_valid) begin
          next_state = ir_entry;
        end else begin
          fault_take = 1'b1;
          fault_code = FLT_ILLEGAL;
        end
      end
      NS_BRT:    next_state = cond ? cr_target : incr;
      NS_BRF:    next_state = cond ? incr : cr_target;
      NS_CALL: begin
        // Single-entry return stack: a nested CALL simply overwrites it.
        ret_reg_nxt   = incr;
        ret_valid_nxt = 1'b1;
        next_state    = cr_target;
      end
      NS_RET: begin
        if (ret_valid) begin
          next_state    = ret_reg;
          ret_valid_nxt = 1'b0;
        end else begin
          fault_take = 1'b1;
          fault_code = FLT_UNDERFLOW;
        end
      end
      NS_WAIT: begin
        // A completing handshake wins over an expiring watchdog.
        if (moc) begin
          next_state = incr;
        end else if (wcnt == WLAST) begin
          fault_take = 1'b1;
          fault_code = FLT_TIMEOUT;
        end else begin
          next_state = state;
          wcnt_nxt   = wcnt + WCW'(1);
        end
      end
      default:   next_state = incr;
    endcase

    if (fault_take) next_state = TRAP_ADDR;
  end

  // Micro-PC, return register, watchdog and fault state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= '0;
      ret_reg     <= '0;
      ret_valid   <= 1'b0;
      wcnt        <= '0;
      fault       <= 2'd0;
      fault_pulse <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register in this block
      // reading the pre-edge values of the others, as real flops would.
      state       <= next_state;
      ret_reg     <= ret_reg_nxt;
      ret_valid   <= ret_valid_nxt;
      wcnt        <= wcnt_nxt;
      fault_pulse <= fault_take;
      // Only the first fault since reset is recorded.
      if (fault_take && (fault == 2'd0)) fault <= fault_code;
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed steps from the test plan
// followed by randomized actions, all compared against an abstract model.
module tb_microsequencer;

  localparam int AW      = 8;
  localparam int TRAP    = 255;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] ns_sel = 3'd0;
  logic       cond = 1'b0;
  logic [7:0] ir_entry = 8'h00;
  logic       ir_valid = 1'b0;
  logic [7:0] cr_target = 8'h00;
  logic       moc = 1'b0;
  logic [7:0] state;
  logic [7:0] next_state;
  logic       stall;
  logic [1:0] fault;
  logic       fault_pulse;

  int vectors = 0;
  int errs    = 0;

  // Abstract model state: micro-PC, return slot, length of the current
  // unbroken memory-wait run, latched fault code, last-cycle fault flag.
  int m_state, m_ret, m_run, m_fault;
  bit m_rv, m_pulse;

  microsequencer #(.AW(AW), .TRAP_ADDR(8'hFF), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .ns_sel     (ns_sel),
    .cond       (cond),
    .ir_entry   (ir_entry),
    .ir_valid   (ir_valid),
    .cr_target  (cr_target),
    .moc        (moc),
    .state      (state),
    .next_state (next_state),
    .stall      (stall),
    .fault      (fault),
    .fault_pulse(fault_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_ret = 0; m_rv = 0; m_run = 0; m_fault = 0; m_pulse = 0;
  endfunction

  // Expected next address and fault code from the action rules.
  function automatic void predict(output int nxt, output int code);
    int inc;
    inc  = (m_state + 1) % (1 << AW);
    code = 0;
    nxt  = inc;
    case (int'(ns_sel))
      0: nxt = 0;
      1: nxt = inc;
      2: if (ir_valid) nxt = int'(ir_entry); else code = 1;
      3: nxt = cond ? int'(cr_target) : inc;
      4: nxt = cond ? inc : int'(cr_target);
      5: nxt = int'(cr_target);
      6: if (m_rv) nxt = m_ret; else code = 2;
      default: begin
        if (moc)                      nxt = inc;
        else if (m_run + 1 >= TIMEOUT) code = 3;
        else                          nxt = m_state;
      end
    endcase
    if (code != 0) nxt = TRAP;
  endfunction

  function automatic void commit(input int nxt, input int code);
    int inc;
    inc = (m_state + 1) % (1 << AW);
    if (ns_sel == 3'd5) begin m_ret = inc; m_rv = 1; end
    if (ns_sel == 3'd6 && m_rv) m_rv = 0;
    m_run   = (ns_sel == 3'd7 && !moc && code == 0) ? m_run + 1 : 0;
    if (m_fault == 0) m_fault = code;
    m_pulse = (code != 0);
    m_state = nxt;
  endfunction

  // One clock cycle: drive, check combinational outputs, clock, check registers.
  task automatic step(input logic [2:0] ns, input logic c, input logic [7:0] ire,
                      input logic irv, input logic [7:0] crt, input logic m);
    int nxt, code;
    ns_sel = ns; cond = c; ir_entry = ire; ir_valid = irv; cr_target = crt; moc = m;
    #1;
    predict(nxt, code);
    chk("next_state", next_state, nxt);
    chk("stall", stall, (ns == 3'd7 && !m));
    @(posedge clk);
    commit(nxt, code);
    #1;
    chk("state", state, m_state);
    chk("fault", fault, m_fault);
    chk("fault_pulse", fault_pulse, m_pulse);
  endtask

  // Asynchronous reset, checked before any clock edge can occur.
  task automatic apply_reset();
    int nxt, code;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_state", state, 0);
    chk("rst_fault", fault, 0);
    chk("rst_fault_pulse", fault_pulse, 0);
    predict(nxt, code);
    chk("rst_next_state", next_state, nxt);
    #1;
    reset = 1'b0;
  endtask

  task automatic jump(input logic [7:0] addr);
    step(3'd3, 1'b1, 8'h00, 1'b1, addr, 1'b1);
  endtask

  task automatic inc();
    step(3'd1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
  endtask

  initial begin
    model_reset();
    #1;
    apply_reset();

    // Increment, decode, illegal opcode, wrap from all-ones.
    repeat (3) inc();
    step(3'd2, 1'b0, 8'h40, 1'b1, 8'h00, 1'b1);
    chk("decode_entry", state, 8'h40);
    step(3'd2, 1'b0, 8'h40, 1'b0, 8'h00, 1'b1);
    chk("illegal_trap", state, 8'hFF);
    chk("illegal_code", fault, 2'd1);
    inc();
    chk("wrap", state, 8'h00);
    chk("pulse_one_cycle", fault_pulse, 1'b0);

    // Conditional branches from 8'h05 toward 8'h20.
    for (int k = 0; k < 4; k++) begin
      jump(8'h05);
      step((k < 2) ? 3'd3 : 3'd4, k[0], 8'h00, 1'b1, 8'h20, 1'b1);
    end

    // Subroutine call/return, then return underflow.
    apply_reset();
    jump(8'h10);
    step(3'd5, 1'b0, 8'h00, 1'b1, 8'h80, 1'b1);
    inc();
    step(3'd6, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
    chk("ret_addr", state, 8'h11);
    step(3'd6, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
    chk("underflow_code", fault, 2'd2);

    // Memory wait satisfied on the third cycle.
    apply_reset();
    jump(8'h30);
    step(3'd7, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    step(3'd7, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    step(3'd7, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
    chk("wait_done", state, 8'h31);

    // Memory timeout: 15 holding edges, trap on the 16th.
    apply_reset();
    jump(8'h30);
    repeat (TIMEOUT) step(3'd7, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    chk("timeout_code", fault, 2'd3);

    // First fault sticks; a later fault still traps and pulses.
    apply_reset();
    step(3'd2, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    jump(8'h30);
    repeat (TIMEOUT) step(3'd7, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    chk("sticky_code", fault, 2'd1);

    // Reset in the middle of a wait discards all context.
    jump(8'h30);
    repeat (5) step(3'd7, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    apply_reset();
    repeat (3) step(3'd7, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);

    // Randomized actions, with occasional asynchronous resets.
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        apply_reset();
      end else begin
        step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0),
             8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
